// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = a - b, LSB first, with a start/busy/done handshake.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    // state | meaning
    // IDLE  | waiting for start; operands latched on the accepting edge
    // SHIFT | one bit per cycle, LSB first
    // DONE  | single-cycle done pulse, d/borrow already valid
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             diff_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        res_next = {diff_bit, res_q[WIDTH-1:1]};

        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_next;
                br_d   = br_next;
                if (cnt_q == CNT_LAST) begin
                    // Counter parks at the terminal count; IDLE clears it on the next accept.
                    d_d      = res_next;
                    borrow_d = br_next;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    ovf_d    = (a_msb_q ^ b_msb_q) & (diff_bit ^ a_msb_q);
`endif
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign d      = d_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH = 8.
// Overflow checks are compiled in only when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .borrow (borrow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Hand-computed vectors: a, b, expected d, borrow, ovf
    logic [7:0] tv_a   [0:5] = '{8'h05, 8'h03, 8'h00, 8'h00, 8'h80, 8'h7F};
    logic [7:0] tv_b   [0:5] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h01, 8'h80};
    logic [7:0] tv_d   [0:5] = '{8'h02, 8'hFE, 8'h00, 8'h01, 8'h7F, 8'hFF};
    logic       tv_br  [0:5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    logic       tv_ovf [0:5] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

    // Presents a request for one edge (E0); returns at the negedge where done is seen.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output logic busy_e0, output int lat);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_e0 = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, borrow} !== 3'b000 || d !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b d=%h borrow=%b, need all zero", busy, done, d, borrow);
        end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %b need 0", ovf);
        end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_start: busy=%b done=%b need 0 0", busy, done);
        end
    endtask

    task automatic test_vectors;
        logic b0;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            do_op(tv_a[i], tv_b[i], b0, lat);
            n_cmp++;
            if (b0 !== 1'b1) begin
                n_err++;
                $display("FAIL vec%0d_busy_after_accept: got %b need 1", i, b0);
            end
            n_cmp++;
            if (lat != 8) begin
                n_err++;
                $display("FAIL vec%0d_latency: got %0d need 8", i, lat);
            end
            n_cmp++;
            if (d !== tv_d[i] || borrow !== tv_br[i]) begin
                n_err++;
                $display("FAIL vec%0d_result: d=%h borrow=%b need d=%h borrow=%b", i, d, borrow, tv_d[i], tv_br[i]);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL vec%0d_busy_with_done: got %b need 0", i, busy);
            end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            n_cmp++;
            if (ovf !== tv_ovf[i]) begin
                n_err++;
                $display("FAIL vec%0d_ovf: got %b need %b", i, ovf, tv_ovf[i]);
            end
`endif
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || d !== tv_d[i]) begin
                n_err++;
                $display("FAIL vec%0d_done_pulse: done=%b d=%h need 0 and %h", i, done, d, tv_d[i]);
            end
        end
    endtask

    // Last vector left d = 0xFF; it must hold while busy and a start during SHIFT is dropped.
    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (lat == 3) begin
                a = 8'hFF; b = 8'hFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            n_cmp++;
            if (busy !== 1'b1 || d !== 8'hFF) begin
                n_err++;
                $display("FAIL hold_while_busy_c%0d: busy=%b d=%h need 1 and ff", lat, busy, d);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_cmp++;
        if (lat != 8 || d !== 8'h0F || borrow !== 1'b0) begin
            n_err++;
            $display("FAIL start_ignored: lat=%0d d=%h borrow=%b need 8 0f 0", lat, d, borrow);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_not_queued: busy=%b need 0", busy);
        end
    endtask

    task automatic test_operand_isolation;
        int lat;
        @(negedge clk);
        a = 8'h55; b = 8'h23; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            a = 8'h00; b = 8'hFF;
            @(negedge clk);
            a = 8'hA5; b = 8'h5A;
            lat++;
        end
        n_cmp++;
        if (lat != 8 || d !== 8'h32 || borrow !== 1'b0) begin
            n_err++;
            $display("FAIL operand_isolation: lat=%0d d=%h borrow=%b need 8 32 0", lat, d, borrow);
        end
    endtask

    // start held high: next accept happens on the first edge seen in IDLE after DONE.
    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        a = 8'h20; b = 8'h10; start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 8 || d !== 8'h10 || borrow !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: lat=%0d d=%h borrow=%b need 8 10 0", lat, d, borrow);
        end
        a = 8'h01; b = 8'h02;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b need 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_reaccept: busy=%b need 1", busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 8 || d !== 8'hFF || borrow !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: lat=%0d d=%h borrow=%b need 8 ff 1", lat, d, borrow);
        end
    endtask

    task automatic test_reset_mid_op;
        logic b0;
        int   lat;
        @(negedge clk);
        a = 8'h80; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, borrow} !== 3'b000 || d !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_op: busy=%b done=%b d=%h borrow=%b need all zero", busy, done, d, borrow);
        end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_op_ovf: got %b need 0", ovf);
        end
`endif
        do_op(8'h09, 8'h04, b0, lat);
        n_cmp++;
        if (lat != 8 || d !== 8'h05 || borrow !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_op: lat=%0d d=%h borrow=%b need 8 05 0", lat, d, borrow);
        end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_ovf: got %b need 0", ovf);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_start_ignored;
        test_operand_isolation;
        test_back_to_back;
        test_reset_mid_op;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
